game_viewport_scaler: RTL and testbench

//   Parametrised successor to the fixed 2x shrink between the VGA timing generator and game_top.

---
 rtl/game_viewport_pkg.sv | 20 ++
 rtl/game_key_edge_strobe.sv | 46 ++++
 rtl/game_viewport_scaler.sv | 206 ++++++++++++++++++++
 tb/tb_game_viewport_scaler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_viewport_pkg.sv
// Shared types and default geometry for the game viewport scaler.
package game_viewport_pkg;

    localparam int unsigned SCREEN_WIDTH   = 640;
    localparam int unsigned SCREEN_HEIGHT  = 480;
    localparam int unsigned MAX_ZOOM_LOG2  = 3;
    localparam int unsigned WORLD_WIDTH    = SCREEN_WIDTH << MAX_ZOOM_LOG2;
    localparam int unsigned WORLD_HEIGHT   = SCREEN_HEIGHT << MAX_ZOOM_LOG2;
    localparam int unsigned ZOOM_WIDTH     = $clog2(MAX_ZOOM_LOG2 + 1);
    localparam int unsigned GAME_RGB_WIDTH = 3;

    typedef logic [ZOOM_WIDTH-1:0] zoom_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

endpackage

// File: rtl/game_key_edge_strobe.sv
// Key group front end: 2-flop synchroniser, rising-edge detect and a
// free-running repeat strobe that pulses once per counter wrap.
module game_key_edge_strobe
    import game_viewport_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned STROBE_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_keys,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic             o_tick
);

    logic [WIDTH-1:0]    r_meta;
    logic [WIDTH-1:0]    r_sync;
    logic [WIDTH-1:0]    r_prev;
    logic [WIDTH-1:0]    r_rise;
    logic [STROBE_W-1:0] r_cnt;
    logic                r_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_rise <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_meta <= i_keys;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_cnt  <= r_cnt + STROBE_W'(1);
            r_tick <= &r_cnt;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_rise;
    assign o_tick  = r_tick;

endmodule

// File: rtl/game_viewport_scaler.sv
// Screen-to-world viewport with runtime zoom-out and pan, committed at frame start.
// Optional GAME_VIEWPORT_BORDER_EN: paints world-edge pixels white while zoomed out.
module game_viewport_scaler
    import game_viewport_pkg::*;
#(
    parameter int unsigned clk_mhz       = 50,
    parameter int unsigned screen_width  = SCREEN_WIDTH,
    parameter int unsigned screen_height = SCREEN_HEIGHT,
    parameter int unsigned max_zoom_log2 = MAX_ZOOM_LOG2,
    parameter int unsigned pan_step      = 8,
    parameter int unsigned strobe_width  = $clog2(clk_mhz * 1000000) - 6,
    parameter int unsigned w_red         = 4,
    parameter int unsigned w_green       = 4,
    parameter int unsigned w_blue        = 4,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height),
    parameter int unsigned w_gx          = w_x + max_zoom_log2,
    parameter int unsigned w_gy          = w_y + max_zoom_log2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 zoom_in_key,
    input  logic                                 zoom_out_key,
    input  logic [3:0]                           pan_keys,
    input  logic                                 display_on,
    input  logic [w_x-1:0]                       x,
    input  logic [w_y-1:0]                       y,
    output logic [w_gx-1:0]                      game_x,
    output logic [w_gy-1:0]                      game_y,
    output logic                                 game_display_on,
    input  logic [GAME_RGB_WIDTH-1:0]            game_rgb,
    output logic [w_red-1:0]                     red,
    output logic [w_green-1:0]                   green,
    output logic [w_blue-1:0]                    blue,
    output logic [$clog2(max_zoom_log2+1)-1:0]   zoom_level
);

    localparam int unsigned W_ZOOM  = $clog2(max_zoom_log2 + 1);
    localparam int unsigned W_SX    = w_gx + 1;
    localparam int unsigned W_SY    = w_gy + 1;
    localparam int unsigned WORLD_W = screen_width << max_zoom_log2;
    localparam int unsigned WORLD_H = screen_height << max_zoom_log2;

    logic [1:0] w_zoom_rise;
    logic [1:0] w_zoom_unused_level;
    logic       w_zoom_unused_tick;
    logic [3:0] w_pan_level;
    logic [3:0] w_pan_unused_rise;
    logic       w_pan_tick;

    game_key_edge_strobe #(.WIDTH(2), .STROBE_W(strobe_width)) u_zoom_keys (
        .clk     (clk),
        .rst     (rst),
        .i_keys  ({zoom_out_key, zoom_in_key}),
        .o_level (w_zoom_unused_level),
        .o_rise  (w_zoom_rise),
        .o_tick  (w_zoom_unused_tick)
    );

    game_key_edge_strobe #(.WIDTH(4), .STROBE_W(strobe_width)) u_pan_keys (
        .clk     (clk),
        .rst     (rst),
        .i_keys  (pan_keys),
        .o_level (w_pan_level),
        .o_rise  (w_pan_unused_rise),
        .o_tick  (w_pan_tick)
    );

    logic [W_ZOOM-1:0] r_zoom_p, r_zoom_c, w_zoom_nx, w_zoom_eff;
    logic [w_gx-1:0]   r_off_x_p, r_off_x_c, w_off_x_nx, w_off_x_eff, w_max_x;
    logic [w_gy-1:0]   r_off_y_p, r_off_y_c, w_off_y_nx, w_off_y_eff, w_max_y;
    logic [W_SX-1:0]   w_sum_x;
    logic [W_SY-1:0]   w_sum_y;
    logic              w_frame_start;

    // Pending zoom/offset: key steps, then saturate against the new zoom's window.
    always_comb begin
        w_zoom_nx = r_zoom_p;
        if (w_zoom_rise == 2'b10 && r_zoom_p != W_ZOOM'(max_zoom_log2))
            w_zoom_nx = r_zoom_p + W_ZOOM'(1);
        else if (w_zoom_rise == 2'b01 && r_zoom_p != '0)
            w_zoom_nx = r_zoom_p - W_ZOOM'(1);

        w_max_x = w_gx'(WORLD_W) - (w_gx'(screen_width) << w_zoom_nx);
        w_max_y = w_gy'(WORLD_H) - (w_gy'(screen_height) << w_zoom_nx);

        w_sum_x = {1'b0, r_off_x_p};
        if (w_pan_tick && w_pan_level[0] && !w_pan_level[1])
            w_sum_x = w_sum_x + W_SX'(pan_step);
        else if (w_pan_tick && w_pan_level[1] && !w_pan_level[0])
            w_sum_x = (r_off_x_p >= w_gx'(pan_step)) ? w_sum_x - W_SX'(pan_step) : '0;

        w_sum_y = {1'b0, r_off_y_p};
        if (w_pan_tick && w_pan_level[2] && !w_pan_level[3])
            w_sum_y = w_sum_y + W_SY'(pan_step);
        else if (w_pan_tick && w_pan_level[3] && !w_pan_level[2])
            w_sum_y = (r_off_y_p >= w_gy'(pan_step)) ? w_sum_y - W_SY'(pan_step) : '0;

        w_off_x_nx = (w_sum_x > {1'b0, w_max_x}) ? w_max_x : w_sum_x[w_gx-1:0];
        w_off_y_nx = (w_sum_y > {1'b0, w_max_y}) ? w_max_y : w_sum_y[w_gy-1:0];
    end

    // The frame-start pixel itself already uses the values being committed.
    assign w_frame_start = display_on && (x == '0) && (y == '0);
    assign w_zoom_eff    = w_frame_start ? r_zoom_p  : r_zoom_c;
    assign w_off_x_eff   = w_frame_start ? r_off_x_p : r_off_x_c;
    assign w_off_y_eff   = w_frame_start ? r_off_y_p : r_off_y_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zoom_p  <= '0;
            r_off_x_p <= '0;
            r_off_y_p <= '0;
            r_zoom_c  <= '0;
            r_off_x_c <= '0;
            r_off_y_c <= '0;
        end else begin
            r_zoom_p  <= w_zoom_nx;
            r_off_x_p <= w_off_x_nx;
            r_off_y_p <= w_off_y_nx;
            if (w_frame_start) begin
                r_zoom_c  <= r_zoom_p;
                r_off_x_c <= r_off_x_p;
                r_off_y_c <= r_off_y_p;
            end
        end
    end

    logic [w_gx-1:0] w_game_x_nx, r_game_x;
    logic [w_gy-1:0] w_game_y_nx, r_game_y;
    logic            r_disp_d1;

    assign w_game_x_nx = w_off_x_eff + (w_gx'(x) << w_zoom_eff);
    assign w_game_y_nx = w_off_y_eff + (w_gy'(y) << w_zoom_eff);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_game_x  <= '0;
            r_game_y  <= '0;
            r_disp_d1 <= 1'b0;
        end else begin
            r_game_x  <= w_game_x_nx;
            r_game_y  <= w_game_y_nx;
            r_disp_d1 <= display_on;
        end
    end

`ifdef GAME_VIEWPORT_BORDER_EN
    logic w_edge, r_edge_d1;

    // Edge flag rides alongside stage 1 so the border adds no latency.
    assign w_edge = (w_zoom_eff != '0) &&
                    (w_game_x_nx == '0 || w_game_x_nx == w_gx'(WORLD_W - 1) ||
                     w_game_y_nx == '0 || w_game_y_nx == w_gy'(WORLD_H - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_edge_d1 <= 1'b0;
        else      r_edge_d1 <= w_edge;
    end
`endif

    rgb_t               w_rgb;
    logic [w_red-1:0]   w_red_nx, r_red;
    logic [w_green-1:0] w_green_nx, r_green;
    logic [w_blue-1:0]  w_blue_nx, r_blue;

    always_comb begin
        w_rgb      = rgb_t'(game_rgb);
        w_red_nx   = '0;
        w_green_nx = '0;
        w_blue_nx  = '0;
        if (r_disp_d1) begin
            w_red_nx   = {w_red{w_rgb.r}};
            w_green_nx = {w_green{w_rgb.g}};
            w_blue_nx  = {w_blue{w_rgb.b}};
`ifdef GAME_VIEWPORT_BORDER_EN
            if (r_edge_d1) begin
                w_red_nx   = '1;
                w_green_nx = '1;
                w_blue_nx  = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= w_red_nx;
            r_green <= w_green_nx;
            r_blue  <= w_blue_nx;
        end
    end

    assign game_x          = r_game_x;
    assign game_y          = r_game_y;
    assign game_display_on = r_disp_d1;
    assign red             = r_red;
    assign green           = r_green;
    assign blue            = r_blue;
    assign zoom_level      = r_zoom_c;

endmodule

// File: tb/tb_game_viewport_scaler.sv
// Directed bench for game_viewport_scaler with a pixel scoreboard and a
// behavioural model of pending/committed zoom and pan offsets.
module tb_game_viewport_scaler;

    localparam int SW       = 640;
    localparam int SH       = 480;
    localparam int MZ       = 3;
    localparam int WW       = SW << MZ;
    localparam int WH       = SH << MZ;
    localparam int STEP     = 8;
    localparam int STROBE_W = 4;
    localparam int PERIOD   = 1 << STROBE_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        zoom_in_key = 1'b0;
    logic        zoom_out_key = 1'b0;
    logic [3:0]  pan_keys = 4'b0;
    logic        display_on = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic [12:0] game_x;
    logic [11:0] game_y;
    logic        game_display_on;
    logic [2:0]  game_rgb;
    logic [3:0]  red, green, blue;
    logic [1:0]  zoom_level;

    game_viewport_scaler #(.strobe_width(STROBE_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .zoom_in_key     (zoom_in_key),
        .zoom_out_key    (zoom_out_key),
        .pan_keys        (pan_keys),
        .display_on      (display_on),
        .x               (x),
        .y               (y),
        .game_x          (game_x),
        .game_y          (game_y),
        .game_display_on (game_display_on),
        .game_rgb        (game_rgb),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .zoom_level      (zoom_level)
    );

    always #5 clk = ~clk;

    // Stand-in for game_top: colour is a pure function of the world coordinate.
    function automatic logic [2:0] fake_rgb(input int gx, input int gy);
        return 3'((gx ^ gy) & 7);
    endfunction

    function automatic logic [11:0] expand(input logic [2:0] c);
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

    always_comb game_rgb = fake_rgb(int'(game_x), int'(game_y));

    typedef struct {
        logic        chk;
        logic        de;
        int          gx;
        int          gy;
        logic [11:0] col;
    } exp_t;

    exp_t q_geo[$];
    exp_t q_col[$];

    int n_total = 0;
    int n_pass  = 0;
    int m_z = 0, m_ox = 0, m_oy = 0;
    int m_zp = 0, m_oxp = 0, m_oyp = 0;

    function automatic int max_ox(input int z);
        return WW - (SW << z);
    endfunction

    function automatic int max_oy(input int z);
        return WH - (SH << z);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: score outputs of earlier pixels, then drive a new pixel.
    task automatic do_pixel(input logic de, input int px, input int py, input logic chk);
        exp_t e;
        @(negedge clk);
        if (q_geo.size() > 0) begin
            e = q_geo.pop_front();
            if (e.chk) begin
                check("game_x", 32'(game_x), 32'(e.gx));
                check("game_y", 32'(game_y), 32'(e.gy));
                check("game_display_on", 32'(game_display_on), 32'(e.de));
            end
        end
        if (q_col.size() > 1) begin
            e = q_col.pop_front();
            if (e.chk) check("rgb", 32'({red, green, blue}), 32'(e.col));
        end
        display_on = de;
        x = 10'(px);
        y = 9'(py);
        if (de && px == 0 && py == 0) begin
            m_z  = m_zp;
            m_ox = m_oxp;
            m_oy = m_oyp;
        end
        e.chk = chk;
        e.de  = de;
        e.gx  = m_ox + (px << m_z);
        e.gy  = m_oy + (py << m_z);
        e.col = de ? expand(fake_rgb(e.gx, e.gy)) : 12'h000;
`ifdef GAME_VIEWPORT_BORDER_EN
        if (de && m_z > 0 && (e.gx == 0 || e.gx == WW - 1 || e.gy == 0 || e.gy == WH - 1))
            e.col = 12'hFFF;
`endif
        q_geo.push_back(e);
        q_col.push_back(e);
    endtask

    task automatic idle(input int n, input logic chk);
        for (int i = 0; i < n; i++) do_pixel(1'b0, 0, 0, chk);
    endtask

    task automatic frame();
        do_pixel(1'b1, 0, 0, 1'b1);
        do_pixel(1'b1, 100, 50, 1'b1);
        do_pixel(1'b1, 101, 0, 1'b1);
        do_pixel(1'b1, 639, 479, 1'b1);
        idle(3, 1'b1);
        check("zoom_level", 32'(zoom_level), 32'(m_z));
    endtask

    task automatic key_pulse(input logic in_k, input logic out_k, input logic vis);
        zoom_in_key  = in_k;
        zoom_out_key = out_k;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                zoom_in_key  = 1'b0;
                zoom_out_key = 1'b0;
            end
            if (vis) do_pixel(1'b1, 300 + i, 7, 1'b1);
            else     do_pixel(1'b0, 0, 0, 1'b0);
        end
        if (in_k != out_k) begin
            if (out_k && m_zp < MZ)     m_zp++;
            else if (in_k && m_zp > 0)  m_zp--;
        end
        if (m_oxp > max_ox(m_zp)) m_oxp = max_ox(m_zp);
        if (m_oyp > max_oy(m_zp)) m_oyp = max_oy(m_zp);
    endtask

    // A hold of k*PERIOD cycles overlaps exactly k repeat strobes.
    task automatic hold_pan(input logic [3:0] keys, input int cycles);
        pan_keys = keys;
        idle(cycles, 1'b0);
        pan_keys = 4'b0;
        idle(6, 1'b0);
        for (int i = 0; i < cycles / PERIOD; i++) begin
            if (keys[0] && !keys[1])      m_oxp = (m_oxp + STEP > max_ox(m_zp)) ? max_ox(m_zp) : m_oxp + STEP;
            else if (keys[1] && !keys[0]) m_oxp = (m_oxp >= STEP) ? m_oxp - STEP : 0;
            if (keys[2] && !keys[3])      m_oyp = (m_oyp + STEP > max_oy(m_zp)) ? max_oy(m_zp) : m_oyp + STEP;
            else if (keys[3] && !keys[2]) m_oyp = (m_oyp >= STEP) ? m_oyp - STEP : 0;
        end
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_game_x"}, 32'(game_x), 32'd0);
        check({tag, "_game_y"}, 32'(game_y), 32'd0);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        check({tag, "_display_on"}, 32'(game_display_on), 32'd0);
        check({tag, "_zoom_level"}, 32'(zoom_level), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zeroed("reset");
        rst = 1'b1;

        // zoom 0, no offset: identity map and colour passthrough
        frame();

        // zoom-out edge mid-frame stays pending until frame start
        key_pulse(1'b0, 1'b1, 1'b1);
        check("zoom_mid_frame", 32'(zoom_level), 32'd0);
        frame();

        // zoom saturates at max and at 0; simultaneous edges ignored
        repeat (3) key_pulse(1'b0, 1'b1, 1'b0);
        frame();
        repeat (4) key_pulse(1'b1, 1'b0, 1'b0);
        frame();
        key_pulse(1'b1, 1'b1, 1'b0);
        frame();

        // zoom 1 pan: saturate right/down, return to 0, opposing keys
        key_pulse(1'b0, 1'b1, 1'b0);
        hold_pan(4'b0101, 500 * PERIOD);
        frame();
        hold_pan(4'b1010, 500 * PERIOD);
        frame();
        hold_pan(4'b0010, 2 * PERIOD);
        hold_pan(4'b0001, 2 * PERIOD);
        hold_pan(4'b0011, 4 * PERIOD);
        hold_pan(4'b1100, 4 * PERIOD);
        frame();

        // zoom 0 full-range offset, then zooming out re-clamps it
        key_pulse(1'b1, 1'b0, 1'b0);
        hold_pan(4'b0001, 600 * PERIOD);
        frame();
        key_pulse(1'b0, 1'b1, 1'b0);
        frame();
        repeat (2) key_pulse(1'b0, 1'b1, 1'b0);
        frame();
        repeat (2) key_pulse(1'b1, 1'b0, 1'b0);
        frame();

        // asynchronous reset in the middle of a frame
        do_pixel(1'b1, 50, 60, 1'b0);
        do_pixel(1'b1, 51, 60, 1'b0);
        #2 rst = 1'b0;
        #1 check_zeroed("mid_reset");
        q_geo.delete();
        q_col.delete();
        m_z = 0; m_ox = 0; m_oy = 0;
        m_zp = 0; m_oxp = 0; m_oyp = 0;
        display_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) do_pixel(1'b1, 20 + i, 3, 1'b1);
        frame();
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
